// File: rtl/regfile_mp_bypass_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
// Holds the zero-register index, the write-lane priority constants and the address-width function.
package regfile_pkg;

  localparam int ZERO_REG = 0;
  localparam int NUM_WR   = 2;
  // Lane 1 carries the younger instruction, so it wins every same-address conflict.
  localparam int LANE_LO  = 0;
  localparam int LANE_HI  = 1;

  function automatic int calc_aw(input int num_regs);
    return (num_regs < 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/regfile_mp_bypass_if.sv
// Decode/writeback-facing bundle of the register file: read ports, write lanes and scoreboard controls.
// The master side drives addresses, write data and scoreboard commands; the slave side is the register file.
interface regfile_mp_bypass_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int AW       = calc_aw(NUM_REGS)
) ();

  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*AW-1:0]     wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     sb_set_en;
  logic [AW-1:0]            sb_set_addr;
  logic [NUM_WR-1:0]        sb_clr_en;
  logic                     any_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, sb_clr_en,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr, sb_clr_en,
    output rd_data, rd_busy, any_busy
  );

endinterface

// File: rtl/regfile_mp_bypass_scoreboard.sv
// Busy-bit scoreboard: decode marks a destination in flight, writeback lanes retire it.
// Produces per-read-port stall bits and the global drain status.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int AW       = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_set_en,
  input  logic [AW-1:0]        i_set_addr,
  input  logic [NUM_WR-1:0]    i_clr_en,
  input  logic [NUM_WR*AW-1:0] i_wr_addr,
  input  logic [NUM_RD*AW-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]    o_rd_busy,
  output logic                 o_any_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Register 0 is skipped entirely, so its busy bit can never leave reset value.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      w_set[r] = i_set_en && (i_set_addr == AW'(r));
      for (int i = 0; i < NUM_WR; i++) begin
        if (i_clr_en[i] && (i_wr_addr[i*AW +: AW] == AW'(r))) begin
          w_clr[r] = 1'b1;
        end
      end
    end
    // A new producer issued in the same cycle as the old one retires keeps the register busy.
    w_busy_nxt = (r_busy & ~w_clr) | w_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_comb begin
    o_rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      o_rd_busy[k] = r_busy[i_rd_addr[k*AW +: AW]] &&
                     !((BYPASS != 0) && w_clr[i_rd_addr[k*AW +: AW]]);
    end
  end

  assign o_any_busy = |r_busy;

endmodule

// File: rtl/regfile_mp_bypass.sv
// Multi-port integer register file: NUM_RD combinational read ports, two writeback lanes,
// optional same-cycle write-to-read bypass and an integrated busy scoreboard.
module regfile_mp_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int AW       = calc_aw(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_mp_bypass_if.slave bus
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic [AW-1:0]     w_wa  [NUM_WR];
  logic [DATA_W-1:0] w_wd  [NUM_WR];
  logic [NUM_WR-1:0] w_we;
  logic [DATA_W-1:0] w_rd  [NUM_RD];

  // Writes to register 0 are dropped here, which also keeps them out of the bypass path.
  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      w_wa[i] = bus.wr_addr[i*AW +: AW];
      w_wd[i] = bus.wr_data[i*DATA_W +: DATA_W];
      w_we[i] = bus.wr_en[i] && (w_wa[i] != AW'(ZERO_REG));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_mem[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_we[LANE_HI] && (w_wa[LANE_HI] == AW'(r))) begin
          r_mem[r] <= w_wd[LANE_HI];
        end else if (w_we[LANE_LO] && (w_wa[LANE_LO] == AW'(r))) begin
          r_mem[r] <= w_wd[LANE_LO];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]     w_ra;
    logic [DATA_W-1:0] w_sel;

    assign w_ra = bus.rd_addr[k*AW +: AW];

    always_comb begin
      w_sel = r_mem[w_ra];
      if (BYPASS != 0) begin
        if (w_we[LANE_HI] && (w_wa[LANE_HI] == w_ra)) begin
          w_sel = w_wd[LANE_HI];
        end else if (w_we[LANE_LO] && (w_wa[LANE_LO] == w_ra)) begin
          w_sel = w_wd[LANE_LO];
        end
      end
      // Held at zero through reset so a write presented during reset cannot leak through the bypass.
      if (!rst_n || (w_ra == AW'(ZERO_REG))) begin
        w_sel = '0;
      end
    end

    assign w_rd[k] = w_sel;
  end

  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      bus.rd_data[k*DATA_W +: DATA_W] = w_rd[k];
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (bus.sb_set_en),
    .i_set_addr (bus.sb_set_addr),
    .i_clr_en   (bus.sb_clr_en),
    .i_wr_addr  (bus.wr_addr),
    .i_rd_addr  (bus.rd_addr),
    .o_rd_busy  (bus.rd_busy),
    .o_any_busy (bus.any_busy)
  );

endmodule
